// File: rtl/gbm_if.sv
// Valid/ready stream bundle for the GBM price-update stage.
interface gbm_if #(
  parameter int WIDTH = 32
);
  logic             valid_in;
  logic             ready_out;
  logic [WIDTH-1:0] z;
  logic [WIDTH-1:0] S;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] sigma;
  logic [WIDTH-1:0] dt;
  logic             valid_out;
  logic             ready_in;
  logic [WIDTH-1:0] S_next;

  modport master (
    output valid_in, z, S, r, sigma, dt, ready_in,
    input  ready_out, valid_out, S_next
  );

  modport slave (
    input  valid_in, z, S, r, sigma, dt, ready_in,
    output ready_out, valid_out, S_next
  );
endinterface

// File: rtl/gbm.sv
// One GBM step S*exp((r - sigma^2/2)*dt + sigma*sqrt(dt)*z), exp as 2nd-order Taylor.
// Pipeline: DIV_LATENCY sqrt stages, exponent, exp, scale; globally stalled by one enable.
module gbm #(
  parameter int WIDTH       = 32,
  parameter int QINT        = 16,
  parameter int QFRAC       = 16,
  parameter int DIV_LATENCY = 5
) (
  input logic clk,
  input logic rst_n,
  gbm_if.slave bus
);
  // Root of a positive Q format value keeps all fraction bits plus half the integer bits.
  localparam int ROOT_W = QFRAC + QINT / 2;
  localparam int RAD_W  = 2 * ROOT_W;
  localparam int REM_W  = ROOT_W + 3;
  localparam int BPS    = (ROOT_W + DIV_LATENCY - 1) / DIV_LATENCY;
  localparam logic signed [WIDTH-1:0] ONE     = WIDTH'(1) << QFRAC;
  localparam logic        [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};

  typedef struct packed {
    logic                    valid;
    logic signed [WIDTH-1:0] drift;
    logic signed [WIDTH-1:0] z;
    logic signed [WIDTH-1:0] S;
    logic signed [WIDTH-1:0] sigma;
  } side_t;

  function automatic logic signed [WIDTH-1:0] fxmul(input logic signed [WIDTH-1:0] a,
                                                    input logic signed [WIDTH-1:0] b);
    logic signed [2*WIDTH-1:0] p;
    p = a * b;
    return WIDTH'(p >>> QFRAC);
  endfunction

  logic en;
  logic v_out;
  logic [WIDTH-1:0] s_out;

  assign en            = !v_out || bus.ready_in;
  assign bus.ready_out = en;
  assign bus.valid_out = v_out;
  assign bus.S_next    = s_out;

  logic signed [WIDTH-1:0] dt_s, r_s, sig_s, ss, drift0;
  logic [RAD_W-1:0] rad0;

  assign dt_s  = $signed(bus.dt);
  assign r_s   = $signed(bus.r);
  assign sig_s = $signed(bus.sigma);

  always_comb begin
    ss     = fxmul(sig_s, sig_s);
    drift0 = fxmul(r_s - (ss >>> 1), dt_s);
    rad0   = '0;
    if (dt_s > 0) rad0 = {{(RAD_W-WIDTH){1'b0}}, bus.dt} << QFRAC;
  end

  logic [RAD_W-1:0]  rad_in [DIV_LATENCY];
  logic [REM_W-1:0]  rem_in [DIV_LATENCY];
  logic [ROOT_W-1:0] root_in [DIV_LATENCY];
  side_t             side_in [DIV_LATENCY];
  logic [RAD_W-1:0]  rad_d [DIV_LATENCY];
  logic [REM_W-1:0]  rem_d [DIV_LATENCY];
  logic [ROOT_W-1:0] root_d [DIV_LATENCY];
  logic [RAD_W-1:0]  rad_q [DIV_LATENCY];
  logic [REM_W-1:0]  rem_q [DIV_LATENCY];
  logic [ROOT_W-1:0] root_q [DIV_LATENCY];
  side_t             side_q [DIV_LATENCY];

  logic [RAD_W-1:0]  rad;
  logic [REM_W-1:0]  rem, trial;
  logic [ROOT_W-1:0] root;

  // Restoring square root, two radicand bits per result bit, BPS result bits per stage.
  always_comb begin
    rad   = '0;
    rem   = '0;
    root  = '0;
    trial = '0;
    rad_in[0]  = rad0;
    rem_in[0]  = '0;
    root_in[0] = '0;
    side_in[0] = {bus.valid_in, drift0, bus.z, bus.S, bus.sigma};
    for (int s = 1; s < DIV_LATENCY; s++) begin
      rad_in[s]  = rad_q[s-1];
      rem_in[s]  = rem_q[s-1];
      root_in[s] = root_q[s-1];
      side_in[s] = side_q[s-1];
    end
    for (int s = 0; s < DIV_LATENCY; s++) begin
      rad  = rad_in[s];
      rem  = rem_in[s];
      root = root_in[s];
      for (int i = s * BPS; i < (s + 1) * BPS && i < ROOT_W; i++) begin
        rem   = {rem[REM_W-3:0], rad[RAD_W-1 -: 2]};
        trial = {1'b0, root, 2'b01};
        if (rem >= trial) begin
          rem  = rem - trial;
          root = {root[ROOT_W-2:0], 1'b1};
        end else begin
          root = {root[ROOT_W-2:0], 1'b0};
        end
        rad = rad << 2;
      end
      rad_d[s]  = rad;
      rem_d[s]  = rem;
      root_d[s] = root;
    end
  end

  side_t side_last;
  logic signed [WIDTH-1:0] sq_s, x_c, e_c;
  logic signed [2*WIDTH-1:0] prod, sh;
  logic [WIDTH-1:0] s_next_c;
  logic v1, v2;
  logic signed [WIDTH-1:0] x1, p1, e2, p2;

  assign side_last = side_q[DIV_LATENCY-1];
  assign sq_s      = $signed({{(WIDTH-ROOT_W){1'b0}}, root_q[DIV_LATENCY-1]});

  always_comb begin
    x_c  = side_last.drift + fxmul(fxmul(side_last.sigma, sq_s), side_last.z);
    e_c  = ONE + x1 + (fxmul(x1, x1) >>> 1);
    prod = p2 * e2;
    sh   = prod >>> QFRAC;
    // S >= 0 and e > 0, so only positive overflow needs clamping.
    s_next_c = (sh > $signed({{WIDTH{1'b0}}, MAX_POS})) ? MAX_POS : sh[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < DIV_LATENCY; s++) begin
        rad_q[s]  <= '0;
        rem_q[s]  <= '0;
        root_q[s] <= '0;
        side_q[s] <= '0;
      end
      v1    <= 1'b0;
      x1    <= '0;
      p1    <= '0;
      v2    <= 1'b0;
      e2    <= '0;
      p2    <= '0;
      v_out <= 1'b0;
      s_out <= '0;
    end else if (en) begin
      for (int s = 0; s < DIV_LATENCY; s++) begin
        rad_q[s]  <= rad_d[s];
        rem_q[s]  <= rem_d[s];
        root_q[s] <= root_d[s];
        side_q[s] <= side_in[s];
      end
      v1    <= side_last.valid;
      x1    <= x_c;
      p1    <= side_last.S;
      v2    <= v1;
      e2    <= e_c;
      p2    <= p1;
      v_out <= v2;
      s_out <= s_next_c;
    end
  end
endmodule

// File: tb/tb_gbm.sv
// Self-checking bench for gbm: spec-level arithmetic model, scoreboard queue, directed vectors.
module tb_gbm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gbm_if #(.WIDTH(32)) bus ();

  gbm #(.WIDTH(32), .QINT(16), .QFRAC(16), .DIV_LATENCY(5)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int checks = 0;
  int failures = 0;
  int acc_count = 0;
  int out_count = 0;
  logic [31:0] exp_q[$];
  bit stall_prev = 1'b0;
  logic [31:0] stall_val = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int fx(input int a, input int b);
    longint p;
    p = longint'(a) * longint'(b);
    return int'(p >>> 16);
  endfunction

  function automatic longint isqrt(input longint v);
    longint q;
    q = longint'($sqrt(real'(v)));
    while (q * q > v) q--;
    while ((q + 1) * (q + 1) <= v) q++;
    return q;
  endfunction

  function automatic logic [31:0] model(input int z, input int s, input int r,
                                        input int sig, input int dt);
    int sq, drift, x, e;
    longint p;
    sq    = (dt <= 0) ? 0 : int'(isqrt(longint'(dt) << 16));
    drift = fx(r - (fx(sig, sig) >>> 1), dt);
    x     = drift + fx(fx(sig, sq), z);
    e     = 32'sh10000 + x + (fx(x, x) >>> 1);
    p     = (longint'(s) * longint'(e)) >>> 16;
    if (p > 64'sh7FFF_FFFF) return 32'h7FFF_FFFF;
    return p[31:0];
  endfunction

  // Scoreboard: sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      chk("ready_out_rule", 32'(bus.ready_out), 32'(!bus.valid_out || bus.ready_in));
      if (stall_prev) begin
        chk("stall_valid_hold", 32'(bus.valid_out), 32'd1);
        chk("stall_data_hold", bus.S_next, stall_val);
      end
      if (bus.valid_in && bus.ready_out) begin
        exp_q.push_back(model(bus.z, bus.S, bus.r, bus.sigma, bus.dt));
        acc_count++;
      end
      if (bus.valid_out && bus.ready_in) begin
        if (exp_q.size() == 0) chk("unexpected_output", 32'd1, 32'd0);
        else chk("stream_value", bus.S_next, exp_q.pop_front());
        out_count++;
      end
      stall_prev = bus.valid_out && !bus.ready_in;
      stall_val  = bus.S_next;
    end
  end

  task automatic rand_tx();
    bus.z     = 32'($urandom_range(0, 6 << 16)) - (32'd3 << 16);
    bus.S     = 32'($urandom_range(0, 32'h00C8_0000));
    bus.r     = 32'($urandom_range(0, 32'h2000));
    bus.sigma = 32'($urandom_range(0, 32'h8000));
    bus.dt    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_8000 : 32'($urandom_range(0, 32'h1_0000));
  endtask

  task automatic send_one(input string name, input logic [31:0] z, input logic [31:0] s,
                          input logic [31:0] r, input logic [31:0] sig, input logic [31:0] dt,
                          input logic [31:0] lit);
    int lat;
    chk({name, "_model"}, model(z, s, r, sig, dt), lit);
    @(posedge clk); #1;
    bus.z = z; bus.S = s; bus.r = r; bus.sigma = sig; bus.dt = dt;
    bus.valid_in = 1'b1;
    bus.ready_in = 1'b1;
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    lat = 1;
    while (!bus.valid_out && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_latency"}, lat, 8);
    chk({name, "_value"}, bus.S_next, lit);
    @(posedge clk); #1;
  endtask

  task automatic back_to_back();
    @(posedge clk); #1;
    bus.valid_in = 1'b1;
    bus.ready_in = 1'b1;
    rand_tx();
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (c < 20) rand_tx();
      else bus.valid_in = 1'b0;
      chk($sformatf("b2b_valid_c%0d", c), 32'(bus.valid_out), 32'(c >= 8 && c <= 27));
    end
  endtask

  task automatic back_pressure();
    int target, out0;
    target = acc_count + 10;
    out0   = out_count;
    for (int g = 0; g < 500; g++) begin
      @(posedge clk); #1;
      if (acc_count >= target) break;
      bus.valid_in = 1'($urandom_range(0, 1));
      bus.ready_in = ($urandom_range(0, 9) >= 3);
      rand_tx();
    end
    bus.valid_in = 1'b0;
    chk("bp_accepted", acc_count, target);
    bus.ready_in = 1'b1;
    for (int g = 0; g < 50; g++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !bus.valid_out) break;
    end
    chk("bp_out_count", out_count - out0, 10);
    chk("bp_queue_empty", exp_q.size(), 0);
  endtask

  task automatic reset_midstream();
    @(posedge clk); #1;
    bus.valid_in = 1'b1;
    bus.ready_in = 1'b1;
    rand_tx();
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      rand_tx();
    end
    chk("pre_reset_valid", 32'(bus.valid_out), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_valid_out", 32'(bus.valid_out), 32'd0);
    chk("rst_s_next", bus.S_next, 32'd0);
    chk("rst_ready_out", 32'(bus.ready_out), 32'd1);
    bus.valid_in = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      chk("no_stale_output", 32'(bus.valid_out), 32'd0);
    end
  endtask

  initial begin
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b1;
    bus.z = '0; bus.S = '0; bus.r = '0; bus.sigma = '0; bus.dt = '0;
    #2;
    chk("reset_valid_out", 32'(bus.valid_out), 32'd0);
    chk("reset_s_next", bus.S_next, 32'd0);
    chk("reset_ready_out", 32'(bus.ready_out), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    send_one("zero_diff", 32'h0001_2345, 32'h0064_0000, 32'h0, 32'h0, 32'h0001_0000, 32'h0064_0000);
    send_one("neg_z", 32'hFFFF_0000, 32'h0064_0000, 32'h0000_2000, 32'h0000_8000, 32'h0001_0000,
             32'h003E_8000);
    send_one("pos_z_sqrt", 32'h0001_0000, 32'h0002_0000, 32'h0000_8000, 32'h0001_0000,
             32'h0000_4000, 32'h0003_4000);
    send_one("saturate", 32'h0, 32'h7FFF_0000, 32'h0001_0000, 32'h0, 32'h0001_0000, 32'h7FFF_FFFF);
    send_one("neg_dt", 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h0001_0000, 32'hFFFF_0000,
             32'h0001_A000);

    back_to_back();
    back_pressure();
    reset_midstream();
    send_one("post_reset", 32'h0001_0000, 32'h0002_0000, 32'h0000_8000, 32'h0001_0000,
             32'h0000_4000, 32'h0003_4000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
